// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - DEPTH x WIDTH storage, one synchronous write port, one asynchronous read port
//
// Ports:
//   clk      in   write clock (posedge)
//   wr_en    in   store wr_data at wr_addr on this edge
//   wr_addr  in   write address
//   wr_data  in   write word
//   rd_addr  in   read address
//   rd_data  out  mem[rd_addr], combinational
module fifo_mem #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  // Contents are deliberately not reset; the pointers in the parent define validity.
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/stream_fifo.sv
// rtl/stream_fifo.sv - valid/ready FIFO with level, almost-full, flush and sticky error flags
//
// Ports:
//   clk          in   clock (posedge)
//   rst_n        in   asynchronous active-low reset
//   flush        in   synchronous clear of pointers and flags
//   wr_valid     in   write request
//   wr_ready     out  space available (!full)
//   wr_data      in   write word
//   rd_valid     out  head word present (!empty)
//   rd_ready     in   consumer takes head word
//   rd_data      out  head word (fall-through)
//   level        out  stored entry count, 0..DEPTH
//   almost_full  out  level >= AF_LVL
//   overflow     out  sticky: write attempted while full
//   underflow    out  sticky: read attempted while empty
module stream_fifo #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 16,
  parameter int AF_LVL = 12
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [WIDTH-1:0]           wr_data,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       almost_full,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PTR_W  = ADDR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0] AF_LVL_V = PTR_W'(AF_LVL);

  generate
    if (WIDTH < 1) begin : g_bad_width
      $error("stream_fifo: WIDTH must be >= 1");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("stream_fifo: DEPTH must be a power of two >= 2");
    end
    if (AF_LVL < 1 || AF_LVL > DEPTH) begin : g_bad_af
      $error("stream_fifo: AF_LVL must be in 1..DEPTH");
    end
  endgenerate

  logic [PTR_W-1:0] w_ptr_q, w_ptr_d;
  logic [PTR_W-1:0] r_ptr_q, r_ptr_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic empty;
  logic full;
  logic wr_fire;
  logic rd_fire;

  // The extra pointer bit distinguishes full (laps differ) from empty (same lap).
  assign empty = (w_ptr_q == r_ptr_q);
  assign full  = (w_ptr_q[ADDR_W] != r_ptr_q[ADDR_W]) &&
                 (w_ptr_q[ADDR_W-1:0] == r_ptr_q[ADDR_W-1:0]);

  assign wr_ready    = !full;
  assign rd_valid    = !empty;
  assign level       = w_ptr_q - r_ptr_q;
  assign almost_full = (level >= AF_LVL_V);
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;

  // Flush overrides any handshake presented in the same cycle.
  assign wr_fire = wr_valid && wr_ready && !flush;
  assign rd_fire = rd_valid && rd_ready && !flush;

  always_comb begin
    w_ptr_d     = w_ptr_q;
    r_ptr_d     = r_ptr_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (flush) begin
      w_ptr_d     = '0;
      r_ptr_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_fire) w_ptr_d = w_ptr_q + PTR_ONE;
      if (rd_fire) r_ptr_d = r_ptr_q + PTR_ONE;
      if (wr_valid && !wr_ready) overflow_d  = 1'b1;
      if (rd_ready && !rd_valid) underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_ptr_q     <= '0;
      r_ptr_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      w_ptr_q     <= w_ptr_d;
      r_ptr_q     <= r_ptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_mem #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_fire),
    .wr_addr (w_ptr_q[ADDR_W-1:0]),
    .wr_data (wr_data),
    .rd_addr (r_ptr_q[ADDR_W-1:0]),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_stream_fifo.sv
// tb/tb_stream_fifo.sv - self-checking bench for stream_fifo (WIDTH=8, DEPTH=4, AF_LVL=3)
module tb_stream_fifo;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int AF = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         wr_valid = 1'b0;
  logic         wr_ready;
  logic [W-1:0] wr_data = '0;
  logic         rd_valid;
  logic         rd_ready = 1'b0;
  logic [W-1:0] rd_data;
  logic [2:0]   level;
  logic         almost_full;
  logic         overflow;
  logic         underflow;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  stream_fifo #(.WIDTH(W), .DEPTH(D), .AF_LVL(AF)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_data     (wr_data),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .rd_data     (rd_data),
    .level       (level),
    .almost_full (almost_full),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: a queue of words plus two sticky flags.
  logic [W-1:0] mq[$];
  bit m_ovf = 1'b0;
  bit m_unf = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (flush) begin
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      int n;
      n = mq.size();
      if (wr_valid && n == D) m_ovf = 1'b1;
      if (rd_ready && n == 0) m_unf = 1'b1;
      if (rd_ready && n > 0) void'(mq.pop_front());
      if (wr_valid && n < D) mq.push_back(wr_data);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_level", 32'(level), 32'(mq.size()));
      check("m_rd_valid", 32'(rd_valid), 32'(mq.size() > 0));
      check("m_wr_ready", 32'(wr_ready), 32'(mq.size() < D));
      check("m_almost_full", 32'(almost_full), 32'(mq.size() >= AF));
      check("m_overflow", 32'(overflow), 32'(m_ovf));
      check("m_underflow", 32'(underflow), 32'(m_unf));
      if (mq.size() > 0) check("m_rd_data", 32'(rd_data), 32'(mq[0]));
    end
  end

  // Present one cycle of stimulus, then return just after the edge that takes it.
  task automatic step(input bit wv, input logic [W-1:0] wd, input bit rr, input bit fl);
    @(negedge clk);
    #1;
    wr_valid = wv;
    wr_data  = wd;
    rd_ready = rr;
    flush    = fl;
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    flush    = 1'b0;
  endtask

  logic [W-1:0] exp_head [6];

  initial begin
    repeat (2) @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_wr_ready", 32'(wr_ready), 32'd1);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_almost_full", 32'(almost_full), 32'd0);

    // Basic: one word through.
    step(1, 8'hA5, 0, 0);
    check("basic_rd_valid", 32'(rd_valid), 32'd1);
    check("basic_rd_data", 32'(rd_data), 32'hA5);
    check("basic_level", 32'(level), 32'd1);
    step(0, 8'h00, 1, 0);
    check("basic_pop_rd_valid", 32'(rd_valid), 32'd0);
    check("basic_pop_level", 32'(level), 32'd0);
    check("basic_pop_underflow", 32'(underflow), 32'd0);

    // Fill to full, then overflow.
    for (int i = 1; i <= 4; i++) begin
      step(1, W'(i), 0, 0);
      check("fill_level", 32'(level), 32'(i));
      check("fill_almost_full", 32'(almost_full), 32'(i >= 3));
      check("fill_wr_ready", 32'(wr_ready), 32'(i < 4));
    end
    step(1, 8'h05, 0, 0);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_level", 32'(level), 32'd4);
    for (int i = 1; i <= 4; i++) begin
      check("drain_data", 32'(rd_data), 32'(i));
      step(0, 8'h00, 1, 0);
    end
    check("drain_empty", 32'(rd_valid), 32'd0);
    step(0, 8'h00, 0, 1);
    check("flush_ovf_clear", 32'(overflow), 32'd0);

    // Wrap: 4 rounds of 3 writes then 3 reads.
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 3; k++) begin
        step(1, W'(8'h20 + r * 3 + k), 0, 0);
        check("wrap_level", 32'(level), 32'(k + 1));
      end
      for (int k = 0; k < 3; k++) begin
        check("wrap_data", 32'(rd_data), 32'(8'h20 + r * 3 + k));
        step(0, 8'h00, 1, 0);
      end
    end

    // Simultaneous read and write at level 2.
    step(1, 8'h30, 0, 0);
    step(1, 8'h31, 0, 0);
    exp_head[0] = 8'h30;
    exp_head[1] = 8'h31;
    for (int i = 2; i < 6; i++) exp_head[i] = 8'h77;
    for (int i = 0; i < 6; i++) begin
      check("simul_head", 32'(rd_data), 32'(exp_head[i]));
      step(1, 8'h77, 1, 0);
      check("simul_level", 32'(level), 32'd2);
    end
    // Full: both asserted, only the read goes.
    step(1, 8'h78, 0, 0);
    step(1, 8'h79, 0, 0);
    check("full_level", 32'(level), 32'd4);
    step(1, 8'h88, 1, 0);
    check("full_both_level", 32'(level), 32'd3);
    check("full_both_ovf", 32'(overflow), 32'd1);
    step(0, 8'h00, 0, 1);

    // Empty read.
    step(0, 8'h00, 1, 0);
    check("empty_underflow", 32'(underflow), 32'd1);
    check("empty_wr_ready", 32'(wr_ready), 32'd1);
    check("empty_level", 32'(level), 32'd0);
    step(1, 8'h10, 0, 0);
    check("empty_then_rd_valid", 32'(rd_valid), 32'd1);
    check("empty_then_rd_data", 32'(rd_data), 32'h10);
    step(0, 8'h00, 0, 1);

    // Flush mid-operation at level 3 with overflow set.
    for (int i = 0; i < 5; i++) step(1, W'(8'h50 + i), 0, 0);
    step(0, 8'h00, 1, 0);
    check("pre_flush_level", 32'(level), 32'd3);
    check("pre_flush_ovf", 32'(overflow), 32'd1);
    step(1, 8'h99, 0, 1);
    check("flush_level", 32'(level), 32'd0);
    check("flush_ovf", 32'(overflow), 32'd0);
    check("flush_rd_valid", 32'(rd_valid), 32'd0);

    // Asynchronous reset between edges.
    step(1, 8'h41, 0, 0);
    step(1, 8'h42, 0, 0);
    check("refill_level", 32'(level), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_rd_valid", 32'(rd_valid), 32'd0);
    check("arst_level", 32'(level), 32'd0);
    check("arst_wr_ready", 32'(wr_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 8'h63, 0, 0);
    check("post_rst_data", 32'(rd_data), 32'h63);
    step(0, 8'h00, 1, 0);
    check("post_rst_level", 32'(level), 32'd0);

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
